inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction-fetch initiator for the instruction ROM (ce/addr/data, combinational read).
//   - Owns the PC and drives the ROM address.
//   - Captures the returned word into the IF/ID pipeline register.
//   - Next-PC sources: sequential +4, ID-stage branch redirect (MIPS delay slot kept),
//     exception flush redirect, and a stall hold from the hazard unit.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset; first word fetched is mem[0]
//   NOP_INST  32'h0000_0000  word placed in IF/ID on flush/bubble (sll $0,$0,0)
// PORTS
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous, active-high reset
//   stall          in   1   hold PC and IF/ID (load-use / multicycle hazard)
//   flush          in   1   exception/eret redirect; kills the word in fetch
//   new_pc         in   32  flush target (exception vector or EPC)
//   branch_flag    in   1   ID resolved a taken branch/jump this cycle
//   branch_target  in   32  ID-computed target
//   inst_ce        out  1   ROM chip enable
//   inst_addr      out  32  ROM byte address (= PC)
//   inst_data      in   32  ROM read word, valid in the same cycle as inst_addr
//   id_pc          out  32  PC of the word held in IF/ID
//   id_inst        out  32  instruction held in IF/ID
//   id_valid       out  1   IF/ID holds a real (non-bubble) instruction
//   id_excp_adel   out  1   fetch address error flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset, at the clock edge with rst=1:
//       pc=RESET_PC, inst_ce=0, id_pc=0, id_inst=NOP_INST, id_valid=0, id_excp_adel=0.
//   - ce sequencing: inst_ce is registered and goes to 1 on the first edge with rst=0;
//     it stays 1 until the next reset. inst_addr=pc at all times.
//   - Latency: the word at inst_addr appears on id_inst one edge after it is presented.
//   - Per-edge priority when inst_ce=1: rst > flush > stall > branch_flag > sequential.
//       flush   : pc<=new_pc; id_inst<=NOP_INST; id_valid<=0. Applies even if stall=1.
//       stall   : pc, id_pc, id_inst, id_valid all hold. A concurrent branch_flag is ignored;
//                 ID re-asserts it after the stall.
//       branch  : pc<=branch_target; IF/ID captures {pc, inst_data}, which is the delay slot
//                 and is never squashed.
//       seq     : pc<=pc+4 (wraps modulo 2^32); IF/ID<={pc, inst_data}; id_valid<=1.
//   - While inst_ce=0, the IF/ID register is loaded with a bubble and pc holds.
//   - Reset asserted mid-stall or mid-branch: reset wins; pending redirects are dropped.
//   - pc[1:0] is passed unmodified to inst_addr; the ROM ignores it (word index = addr>>2).
// CONFIGURATION
//   Macro IF_ALIGN_CHECK_EN.
//   - Defined: if inst_ce=1 and pc[1:0]!=0 and no flush this cycle, then:
//       inst_ce drops combinationally for that cycle;
//       IF/ID<={pc, NOP_INST}, id_valid<=0, id_excp_adel<=1;
//       pc holds until flush.
//     The next flush clears id_excp_adel. Stall still holds the flag.
//   - Undefined: id_excp_adel is tied to 0 and misaligned PCs fetch the enclosing word.
// STRUCTURE
//   - Shared header defines.vh carries:
//       RESET_PC, NOP_INST, ZERO_WORD, INST_ADDR_W=32, INST_W=32;
//       stall/flush enable level constants, reused by the hazard/CP0 units.
//   - Sub-module pc_reg: PC register, ce sequencing and next-PC priority mux.
//   - inst_fetch instantiates pc_reg and implements the IF/ID register plus the alignment check.
// TESTING (bench ROM model loaded with the boot program: mem[0]=0000f025,
//   mem[1]=241d1000, mem[2]=8f990008, mem[3]=04110024)
//   1. Reset release: rst 1->0 -> inst_ce=1, inst_addr=0.
//      Next edge: id_inst=0000f025, id_pc=0, inst_addr=4, id_valid=1.
//   2. Sequential run, 4 edges -> id_inst = 0000f025, 241d1000, 8f990008, 04110024 in order.
//   3. branch_flag with target 0x98 while inst_addr=0x10 -> id_inst=mem[4] (delay slot).
//      Next edge: inst_addr=0x9C and id_pc=0x98.
//   4. stall=1 for 3 cycles at inst_addr=8 -> id_inst/id_pc frozen at mem[1]/4 and inst_addr=8.
//      After release: id_inst=8f990008.
//   5. flush=1 with stall=1 and new_pc=0x80 -> next edge: id_valid=0, id_inst=0, inst_addr=0x80.
//   6. IF_ALIGN_CHECK_EN defined, flush to new_pc=0x82 -> next edge: inst_ce=0, id_excp_adel=1,
//      pc holds at 0x82.
//      Then flush to new_pc=0 -> id_excp_adel=0 and fetch resumes.
//      Also: rst pulsed mid-stall -> all reset values return.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, PC source enum and helpers for instruction fetch
//
// Purpose: constants shared by the fetch stage and the hazard/CP0 units.
//   DEF_RESET_PC / DEF_NOP_INST : default reset PC and bubble word
//   ZERO_WORD                   : all-zero data word
//   INST_ADDR_W / INST_W        : ROM address and instruction widths
//   STALL_EN / FLUSH_EN         : active levels of the stall and flush controls
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0]      DEF_NOP_INST = 32'h0000_0000;
  localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;

  localparam logic STALL_EN = 1'b1;
  localparam logic FLUSH_EN = 1'b1;

  // Selected next-PC source for one edge.
  typedef enum logic [1:0] {
    PC_SRC_HOLD   = 2'd0,
    PC_SRC_FLUSH  = 2'd1,
    PC_SRC_BRANCH = 2'd2,
    PC_SRC_SEQ    = 2'd3
  } pc_src_e;

  // Instruction addresses must be word aligned.
  function automatic logic pc_misaligned(input logic [INST_ADDR_W-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// rtl/inst_fetch_pc_reg.sv - PC register, ROM chip-enable sequencing and next-PC priority mux
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush, new_pc   : exception/eret redirect and its target
//   stall           : hold the PC
//   branch_flag,
//   branch_target   : ID-stage taken branch and its target
//   addr_hold       : misaligned-fetch hold, released only by flush
//   ce              : registered chip enable, 0 in reset, 1 from the first edge after reset
//   pc              : current program counter
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   stall,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  input  logic                   addr_hold,
  output logic                   ce,
  output logic [INST_ADDR_W-1:0] pc
);

  pc_src_e                pc_src;
  logic [INST_ADDR_W-1:0] pc_next;

  // Priority: flush > stall > misaligned hold > branch > sequential.
  // A branch seen during a stall is dropped; ID re-asserts it afterwards.
  always_comb begin
    pc_src = PC_SRC_SEQ;
    if (!ce) begin
      pc_src = PC_SRC_HOLD;
    end else if (flush == FLUSH_EN) begin
      pc_src = PC_SRC_FLUSH;
    end else if (stall == STALL_EN) begin
      pc_src = PC_SRC_HOLD;
    end else if (addr_hold) begin
      pc_src = PC_SRC_HOLD;
    end else if (branch_flag) begin
      pc_src = PC_SRC_BRANCH;
    end
  end

  always_comb begin
    pc_next = pc;
    case (pc_src)
      PC_SRC_FLUSH:  pc_next = new_pc;
      PC_SRC_BRANCH: pc_next = branch_target;
      PC_SRC_SEQ:    pc_next = pc + 32'd4;
      default:       pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce <= 1'b0;
      pc <= RESET_PC;
    end else begin
      ce <= 1'b1;
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, ROM interface and IF/ID pipeline register
//
// Optional feature macro: IF_ALIGN_CHECK_EN (misaligned-PC address-error detection).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   stall                     : hold PC and IF/ID
//   flush, new_pc             : redirect to new_pc and kill the word in fetch
//   branch_flag, branch_target: ID-resolved taken branch (delay slot is kept)
//   inst_ce, inst_addr        : ROM chip enable and byte address (= PC)
//   inst_data                 : ROM word, combinational on inst_addr
//   id_pc, id_inst, id_valid  : IF/ID register contents
//   id_excp_adel              : fetch address error flag
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [INST_W-1:0]      NOP_INST = DEF_NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  output logic                   inst_ce,
  output logic [INST_ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0]      inst_data,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid,
  output logic                   id_excp_adel
);

  logic                   ce_q;
  logic [INST_ADDR_W-1:0] pc;
  logic                   adel_now;

`ifdef IF_ALIGN_CHECK_EN
  // A flush in the same cycle replaces the bad PC, so it does not raise the error.
  assign adel_now = ce_q && pc_misaligned(pc) && (flush != FLUSH_EN);
`else
  assign adel_now = 1'b0;
`endif

  inst_fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .addr_hold    (adel_now),
    .ce           (ce_q),
    .pc           (pc)
  );

  // The ROM is not read while a misaligned PC is parked waiting for the flush.
  assign inst_ce   = ce_q & ~adel_now;
  assign inst_addr = pc;

  // IF/ID register. The word fetched alongside a taken branch is the delay slot
  // and is captured like any sequential word.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc        <= ZERO_WORD;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      id_excp_adel <= 1'b0;
    end else if (!ce_q) begin
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      id_excp_adel <= 1'b0;
    end else if (flush == FLUSH_EN) begin
      id_pc        <= pc;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      id_excp_adel <= 1'b0;
    end else if (stall == STALL_EN) begin
      id_pc        <= id_pc;
      id_inst      <= id_inst;
      id_valid     <= id_valid;
      id_excp_adel <= id_excp_adel;
    end else if (adel_now) begin
      id_pc        <= pc;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      id_excp_adel <= 1'b1;
    end else begin
      id_pc        <= pc;
      id_inst      <= inst_data;
      id_valid     <= 1'b1;
      id_excp_adel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch with a ROM model and IF/ID scoreboard
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_excp_adel;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        chk_pc;
  } ifid_t;

  ifid_t sb[$];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign inst_data = inst_ce ? mem[inst_addr[9:2]] : 32'h0;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .inst_ce      (inst_ce),
    .inst_addr    (inst_addr),
    .inst_data    (inst_data),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .id_excp_adel (id_excp_adel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic valid,
                      input logic chk_pc);
    ifid_t e;
    e.pc = pc; e.inst = inst; e.valid = valid; e.chk_pc = chk_pc;
    sb.push_back(e);
  endtask

  task automatic push_word(input logic [31:0] pc);
    push(pc, mem[pc[9:2]], 1'b1, 1'b1);
  endtask

  task automatic push_bubble();
    push(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    ifid_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("id_inst", id_inst, e.inst);
      chk("id_valid", {31'b0, id_valid}, {31'b0, e.valid});
      if (e.chk_pc) chk("id_pc", id_pc, e.pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h0000f025;
    mem[1] = 32'h241d1000;
    mem[2] = 32'h8f990008;
    mem[3] = 32'h04110024;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0;

    // Reset state
    push(32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("rst_ce", {31'b0, inst_ce}, 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_adel", {31'b0, id_excp_adel}, 32'h0);

    // Reset release: ce rises, PC still at reset value, IF/ID still a bubble
    rst = 1'b0;
    push_bubble();
    tick();
    chk("rel_ce", {31'b0, inst_ce}, 32'h1);
    chk("rel_addr", inst_addr, 32'h0);

    // Sequential run through the boot program
    push_word(32'h0);  tick(); chk("seq_addr4", inst_addr, 32'h4);
    push_word(32'h4);  tick();
    push_word(32'h8);  tick();
    push_word(32'hC);  tick(); chk("seq_addr10", inst_addr, 32'h10);
    chk("boot_w0", mem[0], 32'h0000f025);

    // Branch at 0x10 to 0x98: delay slot mem[4] still enters IF/ID
    branch_flag = 1'b1; branch_target = 32'h98;
    push_word(32'h10); tick(); chk("br_addr", inst_addr, 32'h98);
    branch_flag = 1'b0;
    push_word(32'h98); tick(); chk("br_next_addr", inst_addr, 32'h9C);

    // Redirect to 4, then stall at inst_addr=8 for 3 cycles (one with a branch ignored)
    flush = 1'b1; new_pc = 32'h4;
    push_bubble(); tick(); chk("fl4_addr", inst_addr, 32'h4);
    flush = 1'b0;
    push_word(32'h4); tick(); chk("pre_stall_addr", inst_addr, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_flag = (i == 1); branch_target = 32'h200;
      push(32'h4, 32'h241d1000, 1'b1, 1'b1);
      tick();
      chk("stall_addr", inst_addr, 32'h8);
    end
    stall = 1'b0; branch_flag = 1'b0;
    push(32'h8, 32'h8f990008, 1'b1, 1'b1); tick();
    chk("post_stall_addr", inst_addr, 32'hC);

    // Flush wins over stall
    stall = 1'b1; flush = 1'b1; new_pc = 32'h80;
    push(32'h0, 32'h0, 1'b0, 1'b0); tick();
    chk("fl_stall_addr", inst_addr, 32'h80);
    stall = 1'b0; flush = 1'b0;
    push_word(32'h80); tick();
    chk("fl_resume_addr", inst_addr, 32'h84);

    // PC wraps modulo 2^32
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    push_bubble(); tick();
    flush = 1'b0;
    push_word(32'hFFFF_FFFC); tick();
    chk("wrap_addr", inst_addr, 32'h0);

    // Misaligned flush target
    flush = 1'b1; new_pc = 32'h82;
    push_bubble(); tick();
    flush = 1'b0;
    chk("mis_addr", inst_addr, 32'h82);
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_ce", {31'b0, inst_ce}, 32'h0);
    push_bubble(); tick();
    chk("mis_adel", {31'b0, id_excp_adel}, 32'h1);
    chk("mis_hold_addr", inst_addr, 32'h82);
    chk("mis_ce2", {31'b0, inst_ce}, 32'h0);
    stall = 1'b1;
    push_bubble(); tick();
    chk("mis_stall_adel", {31'b0, id_excp_adel}, 32'h1);
    stall = 1'b0;
    flush = 1'b1; new_pc = 32'h0;
    push_bubble(); tick();
    flush = 1'b0;
    chk("mis_clr_adel", {31'b0, id_excp_adel}, 32'h0);
    chk("mis_clr_ce", {31'b0, inst_ce}, 32'h1);
`else
    chk("mis_ce", {31'b0, inst_ce}, 32'h1);
    push_word(32'h82); tick();
    chk("mis_adel", {31'b0, id_excp_adel}, 32'h0);
    chk("mis_next_addr", inst_addr, 32'h86);
    flush = 1'b1; new_pc = 32'h0;
    push_bubble(); tick();
    flush = 1'b0;
`endif
    chk("resume_addr", inst_addr, 32'h0);
    push_word(32'h0); tick();
    chk("resume_addr4", inst_addr, 32'h4);

    // Reset mid-stall with a pending branch: reset wins
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h300; rst = 1'b1;
    push(32'h0, 32'h0, 1'b0, 1'b1); tick();
    chk("mrst_ce", {31'b0, inst_ce}, 32'h0);
    chk("mrst_addr", inst_addr, 32'h0);
    chk("mrst_adel", {31'b0, id_excp_adel}, 32'h0);
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    push_bubble(); tick();
    chk("mrst_rel_ce", {31'b0, inst_ce}, 32'h1);
    chk("mrst_rel_addr", inst_addr, 32'h0);
    push_word(32'h0); tick();

    chk("sb_empty", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
